// File: rtl/weight_decrypt_loader_if.sv
// Bundle of signals between the weight decrypt loader, its command source
// and the memory_blocks ROM/RAM ports.
//
// Command handshake: start is a request pulse, not a valid/ready pair. It is
// acted on only when the loader is idle and only on a 0->1 change of start,
// so a level held high never retriggers a load. busy is the "not ready"
// indication: 1 from the cycle after an accepted start until the last RAM
// write, then done pulses for exactly one cycle. A start carrying an invalid
// model_sel is answered by a one-cycle error pulse and nothing else.
interface weight_decrypt_loader_if #(
   parameter int N     = 8,
   parameter int DEPTH = 16
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic          start;
   logic [1:0]    model_sel;
   logic [N-1:0]  key;
   logic [1:0]    active_model;
   logic [AW-1:0] rom_addr;
   logic [N-1:0]  rom_data;
   logic [AW-1:0] ram_addr;
   logic [N-1:0]  ram_din;
   logic          ram_write_en;
   logic          busy;
   logic          done;
   logic          error;
   logic [N-1:0]  checksum;
   logic [1:0]    state_dbg;

   // Command source plus ROM data provider.
   modport master (
      output start, model_sel, key, rom_data,
      input  active_model, rom_addr, ram_addr, ram_din, ram_write_en,
             busy, done, error, checksum, state_dbg
   );

   // The loader itself.
   modport slave (
      input  start, model_sel, key, rom_data,
      output active_model, rom_addr, ram_addr, ram_din, ram_write_en,
             busy, done, error, checksum, state_dbg
   );
endinterface

// File: rtl/weight_decrypt_loader.sv
// Weight decrypt loader: streams DEPTH encrypted words from the selected model
// ROM, XORs each with a left-rotating copy of the key and writes the plaintext
// into the weight RAM at the same address. All outputs are registered.
module weight_decrypt_loader #(
   parameter int N     = 8,
   parameter int DEPTH = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   weight_decrypt_loader_if.slave bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        state;
   logic          start_q;
   logic [AW-1:0] rd_idx;
   logic [AW-1:0] wr_idx;
   logic          rd_valid;
   logic [N-1:0]  key_r;
   logic [N-1:0]  dec_word;

   logic [1:0]    active_model_r;
   logic [AW-1:0] ram_addr_r;
   logic [N-1:0]  ram_din_r;
   logic          ram_we_r;
   logic          busy_r;
   logic          done_r;
   logic          error_r;
   logic [N-1:0]  checksum_r;

   // Left rotate of the key by idx mod N; the doubled word makes the
   // wrap-around bits fall out of the upper half.
   function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input logic [AW-1:0] idx);
      logic [2*N-1:0] d;
      int unsigned    sh;
      sh = {{(32-AW){1'b0}}, idx} % N;
      d  = {v, v} << sh;
      return d[2*N-1:N];
   endfunction

   // Plaintext for the word currently on rom_data (word index == wr_idx).
   always_comb begin
      dec_word = bus.rom_data ^ rotl(key_r, wr_idx);
   end

   // Control FSM plus read/write pipeline; every output is a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         start_q        <= 1'b0;
         rd_idx         <= '0;
         wr_idx         <= '0;
         rd_valid       <= 1'b0;
         key_r          <= '0;
         active_model_r <= 2'b00;
         ram_addr_r     <= '0;
         ram_din_r      <= '0;
         ram_we_r       <= 1'b0;
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
         error_r        <= 1'b0;
         checksum_r     <= '0;
      end else begin
         start_q  <= bus.start;
         ram_we_r <= 1'b0;
         error_r  <= 1'b0;
         done_r   <= 1'b0;
         rd_valid <= 1'b0;

         // ROM data arrives one cycle after its address; register the write.
         if (rd_valid) begin
            ram_we_r   <= 1'b1;
            ram_addr_r <= wr_idx;
            ram_din_r  <= dec_word;
            checksum_r <= checksum_r ^ dec_word;
            wr_idx     <= wr_idx + 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (bus.start && !start_q) begin
                  if (bus.model_sel == 2'b01 || bus.model_sel == 2'b10) begin
                     active_model_r <= bus.model_sel;
                     key_r          <= bus.key;
                     checksum_r     <= '0;
                     rd_idx         <= '0;
                     wr_idx         <= '0;
                     busy_r         <= 1'b1;
                     state          <= S_READ;
                  end else begin
                     error_r <= 1'b1;
                  end
               end
            end
            S_READ: begin
               rd_valid <= 1'b1;
               if (rd_idx == LAST_IDX) begin
                  state <= S_DRAIN;
               end else begin
                  rd_idx <= rd_idx + 1'b1;
               end
            end
            S_DRAIN: begin
               // Last write is on the port and no ROM data is pending.
               if (ram_we_r && !rd_valid) begin
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
                  state  <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.active_model = active_model_r;
   assign bus.rom_addr     = rd_idx;
   assign bus.ram_addr     = ram_addr_r;
   assign bus.ram_din      = ram_din_r;
   assign bus.ram_write_en = ram_we_r;
   assign bus.busy         = busy_r;
   assign bus.done         = done_r;
   assign bus.error        = error_r;
   assign bus.checksum     = checksum_r;
   assign bus.state_dbg    = state;
endmodule

// File: tb/tb_weight_decrypt_loader.sv
// Directed bench for weight_decrypt_loader: ROM/RAM models around the DUT,
// an expected-write queue, per-cycle timing checks and hand-computed values.
module tb_weight_decrypt_loader;
   localparam int N     = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int W     = AW + N;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   weight_decrypt_loader_if #(.N(N), .DEPTH(DEPTH)) bus ();

   weight_decrypt_loader #(.N(N), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   int n_cmp = 0;
   int n_err = 0;
   int wr_count = 0;

   logic [N-1:0] rom_a [DEPTH];
   logic [N-1:0] rom_b [DEPTH];
   logic [N-1:0] ram [DEPTH];
   logic [N-1:0] exp_ram [DEPTH];
   logic [N-1:0] exp_cks;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_e;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [N-1:0] rot_key(input logic [N-1:0] v, input int s);
      logic [N-1:0] r;
      for (int b = 0; b < N; b++) r[(b + s) % N] = v[b];
      return r;
   endfunction

   // Registered ROM: data follows the address by one cycle.
   always @(posedge clk) begin
      bus.rom_data <= (bus.active_model == 2'b10) ? rom_b[bus.rom_addr] : rom_a[bus.rom_addr];
   end

   // RAM model and scoreboard on every write strobe.
   always @(posedge clk) begin
      if (rst_n === 1'b1 && bus.ram_write_en === 1'b1) begin
         ram[bus.ram_addr] <= bus.ram_din;
         wr_count <= wr_count + 1;
         if (exp_q.size() == 0) begin
            chk("unexpected_write", {31'd0, bus.ram_write_en}, 32'd0);
         end else begin
            exp_e = exp_q.pop_front();
            chk("wr_addr", 32'(bus.ram_addr), 32'(exp_e[W-1:N]));
            chk("wr_data", 32'(bus.ram_din), 32'(exp_e[N-1:0]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [1:0] sel, input logic [N-1:0] k);
      logic [N-1:0] w;
      exp_cks = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w = ((sel == 2'b10) ? rom_b[i] : rom_a[i]) ^ rot_key(k, i % N);
         exp_ram[i] = w;
         exp_cks ^= w;
         exp_q.push_back({AW'(i), w});
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_active_model"}, 32'(bus.active_model), 32'd0);
      chk({tag, "_rom_addr"},     32'(bus.rom_addr),     32'd0);
      chk({tag, "_ram_addr"},     32'(bus.ram_addr),     32'd0);
      chk({tag, "_ram_din"},      32'(bus.ram_din),      32'd0);
      chk({tag, "_ram_write_en"}, 32'(bus.ram_write_en), 32'd0);
      chk({tag, "_busy"},         32'(bus.busy),         32'd0);
      chk({tag, "_done"},         32'(bus.done),         32'd0);
      chk({tag, "_error"},        32'(bus.error),        32'd0);
      chk({tag, "_checksum"},     32'(bus.checksum),     32'd0);
   endtask

   // Full load: start in the current cycle, then check cycles 1..19.
   // glitch_c > 0 pulses start during that cycle of the load.
   task automatic do_load(input logic [1:0] sel, input logic [N-1:0] k, input int glitch_c);
      int w0;
      push_exp(sel, k);
      w0 = wr_count;
      bus.model_sel = sel;
      bus.key       = k;
      bus.start     = 1'b1;
      tick();
      for (int c = 1; c <= 19; c++) begin
         bus.start = (c == glitch_c);
         chk($sformatf("busy_c%0d", c), 32'(bus.busy), (c <= 18) ? 32'd1 : 32'd0);
         chk($sformatf("we_c%0d", c), 32'(bus.ram_write_en), (c >= 3 && c <= 18) ? 32'd1 : 32'd0);
         chk($sformatf("done_c%0d", c), 32'(bus.done), (c == 19) ? 32'd1 : 32'd0);
         chk($sformatf("rom_addr_c%0d", c), 32'(bus.rom_addr), (c <= 16) ? 32'(c - 1) : 32'd15);
         if (c < 19) tick();
      end
      bus.start = 1'b0;
      chk("write_count", 32'(wr_count - w0), 32'd16);
      chk("checksum", 32'(bus.checksum), 32'(exp_cks));
      chk("active_model", 32'(bus.active_model), 32'(sel));
      for (int i = 0; i < DEPTH; i++) chk($sformatf("ram%0d", i), 32'(ram[i]), 32'(exp_ram[i]));
   endtask

   // Directed stimulus
   initial begin
      int w0;
      logic [N-1:0] cks_keep;
      bus.start     = 1'b0;
      bus.model_sel = 2'b00;
      bus.key       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         rom_a[i] = N'((i * 8'h37) ^ 8'h3C);
         rom_b[i] = '0;
         ram[i]   = '0;
      end
      rom_a[0] = 8'h5A;
      rom_a[1] = 8'h4B;

      // Asynchronous reset, checked before any clock edge
      #1 rst_n = 1'b0;
      #2 chk_all_zero("reset");
      tick();
      tick();
      rst_n = 1'b1;

      // Idle: no writes without a start
      w0 = wr_count;
      repeat (50) tick();
      chk("idle_writes", 32'(wr_count - w0), 32'd0);
      chk("idle_busy", 32'(bus.busy), 32'd0);

      // Key wrap on model B (ROM all zero, so RAM holds the keystream)
      do_load(2'b10, 8'h81, 0);
      chk("wrap_ram1", 32'(ram[1]), 32'h03);
      chk("wrap_ram8", 32'(ram[8]), 32'h81);
      chk("wrap_cks", 32'(bus.checksum), 32'h00);
      tick();

      // Model A
      do_load(2'b01, 8'hA5, 0);
      chk("a_ram0", 32'(ram[0]), 32'hFF);
      chk("a_ram1", 32'(ram[1]), 32'h00);
      chk("a_active", 32'(bus.active_model), 32'h1);
      cks_keep = exp_cks;
      tick();

      // Invalid select
      w0 = wr_count;
      bus.model_sel = 2'b11;
      bus.key       = 8'h77;
      bus.start     = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("inv_error_c1", 32'(bus.error), 32'd1);
      chk("inv_busy_c1", 32'(bus.busy), 32'd0);
      tick();
      chk("inv_error_c2", 32'(bus.error), 32'd0);
      chk("inv_busy_c2", 32'(bus.busy), 32'd0);
      chk("inv_active", 32'(bus.active_model), 32'h1);
      chk("inv_cks", 32'(bus.checksum), 32'(cks_keep));
      repeat (5) tick();
      chk("inv_writes", 32'(wr_count - w0), 32'd0);

      // Start pulsed mid-load is ignored; start right after done is taken
      do_load(2'b10, 8'h3C, 5);
      tick();
      do_load(2'b01, 8'h5E, 0);
      tick();

      // Reset at cycle 8 of a load
      push_exp(2'b01, 8'hC3);
      bus.model_sel = 2'b01;
      bus.key       = 8'hC3;
      bus.start     = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (7) tick();
      chk("mid_we_before_rst", 32'(bus.ram_write_en), 32'd1);
      rst_n = 1'b0;
      #1 chk_all_zero("midrst");
      exp_q.delete();
      tick();
      chk("midrst_done", 32'(bus.done), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("after_rst_done", 32'(bus.done), 32'd0);
      do_load(2'b10, 8'h96, 0);
      tick();

      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/weight_decrypt_loader.md
Name: weight_decrypt_loader

Overview:
Control stage that sits directly upstream of the weight RAM and downstream of the model ROMs in memory_blocks.
- On a start command it selects the model and streams all DEPTH encrypted ROM words.
- It decrypts each word with a rotating XOR keystream and writes the plaintext into RAM at the same address.
- It drives active_model, rom_addr and the RAM write port of memory_blocks, and reports busy/done/error plus a checksum.

Parameters:
N, 8, weight word width (also the key width)
DEPTH, 16, number of words per model; address width AW = $clog2(DEPTH)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  load request, sampled only in IDLE
model_sel  input  2  requested model: 01 = A, 10 = B, other values invalid
key  input  N  decryption key, latched on accepted start
active_model  output  2  model select to memory ROM mux
rom_addr  output  AW  ROM read address; ROM returns data 1 cycle later (registered)
rom_data  input  N  encrypted word from memory_blocks
ram_addr  output  AW  RAM write address (registered)
ram_din  output  N  decrypted word (registered)
ram_write_en  output  1  RAM write strobe (registered)
busy  output  1  load in progress
done  output  1  one-cycle pulse when the load completes
error  output  1  one-cycle pulse when start is rejected for an invalid model_sel
checksum  output  N  XOR of all decrypted words from the last load

Behaviour:
- Reset values (async, rst_n low): all outputs are 0; state IDLE; internal counters 0.
- States:
  - IDLE -> READ on start with model_sel in {01, 10}.
  - READ -> DRAIN after address DEPTH-1 is issued.
  - DRAIN -> DONE once the final write has been presented.
  - DONE -> IDLE unconditionally, after 1 cycle.
- Start acceptance, at edge E0 (start=1 in IDLE, valid model_sel):
  - latch active_model <= model_sel and key_r <= key;
  - clear checksum and the read/write indices.
- Invalid model_sel at start: error = 1 for 1 cycle; stay in IDLE; active_model, checksum and RAM are untouched.
- Cycle numbering: cycle 1 is the first cycle after E0.
- Read side: in cycles 1..DEPTH, rom_addr = rd_idx = 0..DEPTH-1, one address per cycle with no gaps. rom_addr holds its last value afterwards.
- Valid pipeline: a 1-bit register tracks that rom_data is valid, 1 cycle after each issued address (cycles 2..DEPTH+1).
- Decrypt: word i is rom_data XOR rotl(key_r, i mod N), where rotl is a left rotate of the N-bit key. Word index i equals wr_idx.
- Write side, registered: in cycles 3..DEPTH+2, ram_write_en = 1, ram_addr = i, ram_din = decrypted word i.
  - ram_write_en is 0 in every other cycle.
  - ram_addr and ram_din hold their last value when not writing.
- checksum is updated with each decrypted word as it is registered. It is final and stable from cycle DEPTH+3 until the next accepted start.
- busy = 1 in cycles 1..DEPTH+2 and 0 otherwise.
- done = 1 only in cycle DEPTH+3. Total latency from start to done is DEPTH+3 cycles (19 for the defaults).
- active_model holds its value after done so downstream ROM reads stay on the loaded model. It changes only on an accepted start or reset.
- start is ignored while busy, in DONE, or when held high; a new load needs start sampled in IDLE. Back-to-back loads are allowed: start in the cycle after done is accepted.
- Index wrap: rd_idx and wr_idx are AW bits. The last address is DEPTH-1 and there is no wrap within one load. DEPTH does not need to be a power of 2; the terminal count compares against DEPTH-1.
- Keystream rotation wraps every N words; word N uses the unrotated key again.
- Reset mid-load aborts immediately:
  - ram_write_en drops asynchronously;
  - the RAM contents are left partially written;
  - done is not pulsed and checksum is 0.

Test Plan:
- Reset, then idle: with rst_n low, all outputs are 0; after release with no start, ram_write_en never asserts for 50 cycles.
- Model A load: rom_a[0] = 5A, rom_a[1] = 4B, key = A5.
  - Required: ram[0] = FF and ram[1] = 00.
  - Required: the first write is in cycle 3, done is in cycle 19, busy is high in cycles 1..18, active_model = 01.
- Key wrap: rom_b all 00, key = 81, model_sel = 10.
  - Required: ram[i] = rotl(81, i mod 8), so ram[1] = 03 and ram[8] = 81.
  - Required: checksum equals the XOR of all 16 words, which is 00.
- Invalid select: start with model_sel = 11.
  - Required: error pulse for 1 cycle, busy stays 0, active_model keeps its previous value, no RAM writes.
- start pulsed at cycle 5 of a load: ignored, exactly 16 writes, a single done. Start in the cycle after done starts a second load.
- rst_n low at cycle 8 of a load: all outputs go to 0 immediately, no done. A subsequent full load completes correctly.
